// File: rtl/sq_hit_report_pkg.sv
// Shared game constants: counter widths, FSM encoding and register field layout
// for the tile/foot hit report block.
package sq_hit_report_pkg;

    localparam int CNT_W       = 12;
    localparam int FRAME_CNT_W = 6;
    localparam int RES_FLD_W   = 12;

    localparam int PRD_VALID_BIT   = 31;
    localparam int PRD_OVERRUN_BIT = 30;
    localparam int PRD_FRAME_LSB   = 24;
    localparam int PRD_RES_R_LSB   = 12;
    localparam int PRD_RES_L_LSB   = 0;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        COUNT      = 1'b1
    } state_t;

endpackage

// File: rtl/sq_hit_report_sat_counter.sv
// Saturating up-counter; clr reloads to inc (0 or 1) so the clearing cycle still counts.
// Latency: q updates one clk after inc/clr.
// Backpressure: none, counts every qualifying cycle and sticks at all-ones.
module sat_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         res,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (res) begin
            q <= '0;
        end else if (clr) begin
            q <= W'(inc);
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/sq_hit_report.sv
// Counts per-frame overlap of each foot sprite with the white tile, snapshots on animate.
// Latency: snapshot visible one clk after animate; prdata is combinational on the read strobe.
// Backpressure: none; an unread result overwritten by the next snapshot raises overrun.
module sq_hit_report #(
    parameter int CNT_W = sq_hit_report_pkg::CNT_W
) (
    input  logic        clk,
    input  logic        res,
    input  logic        animate,
    input  logic        sq,
    input  logic        foot_l_px,
    input  logic        foot_r_px,
    input  logic        read_en,
    input  logic        right_addr,
    output logic [31:0] prdata,
    output logic        irq
);

    import sq_hit_report_pkg::*;

    state_t                 state_q;
    state_t                 state_d;
    logic                   counting;
    logic                   snap;
    logic                   rd;
    logic                   hit_l;
    logic                   hit_r;
    logic [CNT_W-1:0]       acc_l;
    logic [CNT_W-1:0]       acc_r;
    logic [CNT_W-1:0]       res_l;
    logic [CNT_W-1:0]       res_r;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   valid;
    logic                   overrun;

    assign rd    = read_en & right_addr;
    assign hit_l = sq & foot_l_px;
    assign hit_r = sq & foot_r_px;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= WAIT_FRAME;
        end else begin
            state_q <= state_d;
        end
    end

    // The arming animate only leaves WAIT_FRAME; it never snapshots.
    always_comb begin
        state_d  = state_q;
        counting = 1'b0;
        snap     = 1'b0;
        case (state_q)
            WAIT_FRAME: begin
                if (animate) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                counting = 1'b1;
                snap     = animate;
            end
            default: begin
                state_d = WAIT_FRAME;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_cnt_l (
        .clk (clk),
        .res (res),
        .clr (snap),
        .inc (counting & hit_l),
        .q   (acc_l)
    );

    sat_counter #(.W(CNT_W)) u_cnt_r (
        .clk (clk),
        .res (res),
        .clr (snap),
        .inc (counting & hit_r),
        .q   (acc_r)
    );

    // A read coinciding with a snapshot consumes the old result, so no overrun.
    always_ff @(posedge clk) begin
        if (res) begin
            res_l     <= '0;
            res_r     <= '0;
            frame_cnt <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else if (snap) begin
            res_l     <= acc_l;
            res_r     <= acc_r;
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            valid     <= 1'b1;
            overrun   <= valid & ~rd;
        end else if (rd) begin
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end
    end

    always_comb begin
        prdata = '0;
        if (rd) begin
            prdata[PRD_VALID_BIT]                   = valid;
            prdata[PRD_OVERRUN_BIT]                 = overrun;
            prdata[PRD_FRAME_LSB +: FRAME_CNT_W]    = frame_cnt;
            prdata[PRD_RES_R_LSB +: RES_FLD_W]      = RES_FLD_W'(res_r);
            prdata[PRD_RES_L_LSB +: RES_FLD_W]      = RES_FLD_W'(res_l);
        end
    end

    assign irq = valid;

endmodule

// File: tb/tb_sq_hit_report.sv
// Directed scenarios followed by random traffic, all checked against a frame-level
// reference model of the hit report register.
module tb_sq_hit_report;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        animate = 1'b0;
    logic        sq = 1'b0;
    logic        foot_l_px = 1'b0;
    logic        foot_r_px = 1'b0;
    logic        read_en = 1'b0;
    logic        right_addr = 1'b0;
    logic [31:0] prdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit m_armed = 0;
    int m_al = 0, m_ar = 0, m_rl = 0, m_rr = 0, m_fc = 0;
    bit m_valid = 0, m_ov = 0;

    logic [31:0] last_prdata;
    logic        last_irq;

    localparam int SAT = 4095;

    sq_hit_report #(.CNT_W(12)) dut (
        .clk        (clk),
        .res        (res),
        .animate    (animate),
        .sq         (sq),
        .foot_l_px  (foot_l_px),
        .foot_r_px  (foot_r_px),
        .read_en    (read_en),
        .right_addr (right_addr),
        .prdata     (prdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        w        = '0;
        w[31]    = m_valid;
        w[30]    = m_ov;
        w[29:24] = m_fc[5:0];
        w[23:12] = m_rr[11:0];
        w[11:0]  = m_rl[11:0];
        return w;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < SAT) ? v + 1 : SAT;
    endfunction

    // Drive one cycle: inputs set just after an edge, outputs checked before the next.
    task automatic tick(input bit rs, input bit an, input bit s, input bit fl,
                        input bit fr, input bit re, input bit ra);
        bit rd;
        bit hl;
        bit hr;
        res = rs; animate = an; sq = s; foot_l_px = fl; foot_r_px = fr;
        read_en = re; right_addr = ra;
        #3;
        rd = re && ra;
        last_prdata = prdata;
        last_irq    = irq;
        check_eq("prdata", prdata, rd ? model_word() : 32'h0);
        check_eq("irq", {31'h0, irq}, {31'h0, m_valid});
        @(posedge clk);
        hl = s && fl;
        hr = s && fr;
        if (rs) begin
            m_armed = 0; m_al = 0; m_ar = 0; m_rl = 0; m_rr = 0; m_fc = 0;
            m_valid = 0; m_ov = 0;
        end else if (!m_armed) begin
            if (an) m_armed = 1;
            if (rd) begin m_valid = 0; m_ov = 0; end
        end else if (an) begin
            m_rl    = m_al;
            m_rr    = m_ar;
            m_fc    = (m_fc + 1) % 64;
            m_ov    = m_valid && !rd;
            m_valid = 1;
            m_al    = hl ? 1 : 0;
            m_ar    = hr ? 1 : 0;
        end else begin
            if (hl) m_al = sat_inc(m_al);
            if (hr) m_ar = sat_inc(m_ar);
            if (rd) begin m_valid = 0; m_ov = 0; end
        end
        #1;
    endtask

    task automatic idle();        tick(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic anim();        tick(0, 1, 0, 0, 0, 0, 0); endtask
    task automatic rd_reg();      tick(0, 0, 0, 0, 0, 1, 1); endtask
    task automatic hit(input bit l, input bit r); tick(0, 0, 1, l, r, 0, 0); endtask

    initial begin
        @(posedge clk);
        #1;
        tick(1, 1, 1, 1, 1, 1, 1);
        tick(1, 0, 0, 0, 0, 0, 0);
        rd_reg();
        check_eq("reset_read", last_prdata, 32'h0);
        check_eq("reset_irq", {31'h0, last_irq}, 32'h0);

        // ten left hits in one frame
        anim();
        for (int i = 0; i < 10; i++) hit(1, 0);
        anim();
        rd_reg();
        check_eq("basic_read", last_prdata, 32'h8100000A);
        check_eq("basic_irq_at_read", {31'h0, last_irq}, 32'h1);
        idle();
        check_eq("basic_irq_after", {31'h0, last_irq}, 32'h0);

        // right counter saturation
        for (int i = 0; i < 5000; i++) hit(0, 1);
        anim();
        rd_reg();
        check_eq("sat_read", last_prdata, 32'h82FFF000);

        // overrun after two unread snapshots
        anim();
        anim();
        rd_reg();
        check_eq("overrun_read", last_prdata, 32'hC4000000);
        rd_reg();
        check_eq("overrun_cleared", last_prdata, 32'h04000000);

        // read coincides with snapshot
        for (int i = 0; i < 3; i++) hit(1, 0);
        anim();
        for (int i = 0; i < 2; i++) hit(1, 0);
        tick(0, 1, 0, 0, 0, 1, 1);
        check_eq("coincide_old", last_prdata, 32'h85000003);
        idle();
        check_eq("coincide_irq", {31'h0, last_irq}, 32'h1);
        rd_reg();
        check_eq("coincide_new", last_prdata, 32'h86000002);

        // reset mid-frame, hits before arming ignored
        for (int i = 0; i < 3; i++) hit(1, 1);
        tick(1, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) hit(1, 1);
        tick(0, 1, 1, 1, 1, 0, 0);
        anim();
        rd_reg();
        check_eq("rearm_read", last_prdata, 32'h81000000);

        // frame counter wrap, and unaddressed read
        for (int i = 0; i < 63; i++) anim();
        tick(0, 0, 0, 0, 0, 1, 0);
        check_eq("noaddr_read", last_prdata, 32'h0);
        idle();
        check_eq("noaddr_irq", {31'h0, last_irq}, 32'h1);
        rd_reg();
        check_eq("wrap_read", last_prdata, 32'hC0000000);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sq_hit_report.md
SQ_HIT_REPORT -- requirements
Module: sq_hit_report

Interface
REQ-001 SHALL have parameter CNT_W, default 12, meaning width of each per-foot overlap counter.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port res  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port animate  input  1  one-cycle frame-boundary pulse.
REQ-005 SHALL have port sq  input  1  current pixel lies inside the white tile.
REQ-006 SHALL have port foot_l_px  input  1  current pixel lies inside the left-foot sprite.
REQ-007 SHALL have port foot_r_px  input  1  current pixel lies inside the right-foot sprite.
REQ-008 SHALL have port read_en  input  1  APB read strobe; high for exactly one cycle per read.
REQ-009 SHALL have port right_addr  input  1  APB address decode hit for this block's register.
REQ-010 SHALL have port prdata  output  32  read data.
REQ-011 SHALL have port irq  output  1  high while an unread frame result is held.

Function
REQ-012 SHALL implement FSM states WAIT_FRAME and COUNT; reset enters WAIT_FRAME; animate in WAIT_FRAME moves to COUNT; COUNT persists until reset.
REQ-013 In WAIT_FRAME, SHALL not count pixels and SHALL not snapshot.
REQ-014 In COUNT, SHALL increment acc_l by one on each cycle where sq & foot_l_px, and acc_r on each cycle where sq & foot_r_px; both may increment in the same cycle.
REQ-015 Accumulators SHALL saturate at 2^CNT_W-1 (4095) and never wrap.
REQ-016 On animate in COUNT, SHALL copy acc_l/acc_r into res_l/res_r, increment 6-bit frame_cnt (wraps 63->0), and set valid, all in the same cycle.
REQ-017 On that animate cycle, accumulators SHALL load 1 if that cycle's hit condition is true, else 0; that pixel belongs to the new frame.
REQ-018 On animate in COUNT with valid already 1 and no read in the same cycle, SHALL set overrun; res_l/res_r SHALL still be overwritten.
REQ-019 prdata SHALL be combinational: {valid, overrun, frame_cnt[5:0], res_r[11:0], res_l[11:0]} (bit 31 down to bit 0) when read_en & right_addr, else 32'h0.
REQ-020 A read (read_en & right_addr) SHALL clear valid and overrun at the next edge, unless a snapshot occurs in the same cycle.
REQ-021 If a read and a snapshot coincide, SHALL return the old result, leave valid=1 with the new result, and leave overrun=0.
REQ-022 irq SHALL equal valid.

Reset
REQ-023 res SHALL take priority over all inputs, including animate and read.
REQ-024 On res, SHALL set state=WAIT_FRAME, acc_l=acc_r=0, res_l=res_r=0, frame_cnt=0, valid=0, overrun=0, irq=0.
REQ-025 Reset mid-frame SHALL discard partial counts; the next animate only re-arms (REQ-012) and SHALL not snapshot.

Structure
REQ-026 CNT_W, the FRAME_CNT width (6), the state encodings and the prdata bit positions SHALL reside in the shared game package.
REQ-027 SHALL instantiate sub-module sat_counter twice (ports clk, res, clr, inc, q), one per foot.

Verification
REQ-028 Scenario: reset, one animate, 10 cycles of sq & foot_l_px, animate, read -> prdata = 32'h8100000A; irq falls one cycle after the read.
REQ-029 Scenario: 5000 cycles of sq & foot_r_px in COUNT, then animate, then read -> res_r=4095 (saturated); res_l=0.
REQ-030 Scenario: two snapshots with no read, then a read -> bit30 (overrun)=1, bit31=1; a second read returns overrun=0 and valid=0.
REQ-031 Scenario: read and animate in the same cycle -> old result is returned; valid stays 1; overrun=0; the next read shows the new result.
REQ-032 Scenario: hits before the first animate -> none are counted; the first snapshot after a reset mid-frame has frame_cnt=1 and both counts 0 when no hits occur.
REQ-033 Scenario: 64 snapshots -> frame_cnt wraps to 0; read_en with right_addr=0 -> prdata=0 and valid is unchanged.
